// File: rtl/trace_access_driver.sv
// trace_access_driver
//   Initiator side of the cache-simulator access interface. Decoded trace
//   records (op, address) arrive over a valid/ready handshake, are buffered in
//   a FIFO, and are issued to the cache model as single-cycle accesses
//   (acc_valid qualifies rw/address). Also sequences the cache clear pulse and
//   the statistics dump handshake.
// Ports
//   clk, reset                      clock, async active-high reset
//   in_valid/in_ready/in_op/in_addr trace record input handshake
//   acc_valid/rw/address            access strobe and payload to the cache
//   cache_reset                     two-cycle clear pulse to the cache model
//   dump_req/dump_ack               stats dump request, held until acknowledged
//   fifo_count                      current FIFO occupancy
//   issued_reads/issued_writes      saturating issued-access counters
//   bad_ops                         saturating count of undefined op codes
//   idle                            state IDLE and FIFO empty
module trace_access_driver #(
  parameter int unsigned ADDRESS_SIZE = 16,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned GAP          = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_op,
  input  logic [ADDRESS_SIZE-1:0]      in_addr,
  output logic                         acc_valid,
  output logic                         rw,
  output logic [ADDRESS_SIZE-1:0]      address,
  output logic                         cache_reset,
  output logic                         dump_req,
  input  logic                         dump_ack,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [31:0]                  issued_reads,
  output logic [31:0]                  issued_writes,
  output logic [31:0]                  bad_ops,
  output logic                         idle
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned GCNT_W = 4;
  localparam bit          NO_GAP = (GAP == 0);

  typedef struct packed {
    logic [3:0]              op;
    logic [ADDRESS_SIZE-1:0] addr;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_CLEAR,
    S_DUMP
  } state_t;

  // Saturating increment for the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  rec_t                    mem [DEPTH];
  rec_t                    in_rec;
  rec_t                    head;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [GCNT_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                    clr_cnt_q, clr_cnt_d;
  logic                    acc_valid_q, acc_valid_d;
  logic                    rw_q, rw_d;
  logic [ADDRESS_SIZE-1:0] address_q, address_d;
  logic                    cache_reset_q, cache_reset_d;
  logic                    dump_req_q, dump_req_d;
  logic [31:0]             reads_q, reads_d;
  logic [31:0]             writes_q, writes_d;
  logic [31:0]             bad_q, bad_d;
  logic                    idle_q, idle_d;
  logic                    push, pop, decision;

  // Ready is combinational from the registered count so a full FIFO never pushes.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr_q];

  always_comb begin
    in_rec.op   = in_op;
    in_rec.addr = in_addr;
  end

  // FIFO storage; no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_rec;
  end

  // Next-state, output and counter logic.
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    clr_cnt_d     = clr_cnt_q;
    acc_valid_d   = 1'b0;
    rw_d          = rw_q;
    address_d     = address_q;
    cache_reset_d = 1'b0;
    dump_req_d    = 1'b0;
    reads_d       = reads_q;
    writes_d      = writes_q;
    bad_d         = bad_q;
    pop           = 1'b0;

    decision = (state_q == S_IDLE) || ((state_q == S_ISSUE) && NO_GAP);

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_ISSUE: begin
        if (!NO_GAP) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        // Leave after GAP cycles spent in this state.
        if ((5'(gap_cnt_q) + 5'd1) >= 5'(GAP)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GCNT_W'(1);
        end
      end
      S_CLEAR: begin
        if (!clr_cnt_q) begin
          cache_reset_d = 1'b1;
          clr_cnt_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DUMP: begin
        // Request drops in the cycle after the acknowledge is seen.
        if (dump_ack) begin
          state_d = S_IDLE;
        end else begin
          dump_req_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Decision point: pop and dispatch the head record.
    if (decision && (count_q != '0)) begin
      pop = 1'b1;
      case (head.op)
        4'd0, 4'd2: begin
          state_d     = S_ISSUE;
          acc_valid_d = 1'b1;
          rw_d        = 1'b0;
          address_d   = head.addr;
          reads_d     = sat_inc(reads_q);
        end
        4'd1: begin
          state_d     = S_ISSUE;
          acc_valid_d = 1'b1;
          rw_d        = 1'b1;
          address_d   = head.addr;
          writes_d    = sat_inc(writes_q);
        end
        4'd8: begin
          state_d       = S_CLEAR;
          cache_reset_d = 1'b1;
          clr_cnt_d     = 1'b0;
        end
        4'd9: begin
          state_d    = S_DUMP;
          dump_req_d = 1'b1;
        end
        default: begin
          // Undefined op: dropped, remain at the decision point.
          bad_d   = sat_inc(bad_q);
          state_d = S_IDLE;
        end
      endcase
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    idle_d   = (state_d == S_IDLE) && (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      gap_cnt_q     <= '0;
      clr_cnt_q     <= 1'b0;
      acc_valid_q   <= 1'b0;
      rw_q          <= 1'b0;
      address_q     <= '0;
      cache_reset_q <= 1'b0;
      dump_req_q    <= 1'b0;
      reads_q       <= '0;
      writes_q      <= '0;
      bad_q         <= '0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      gap_cnt_q     <= gap_cnt_d;
      clr_cnt_q     <= clr_cnt_d;
      acc_valid_q   <= acc_valid_d;
      rw_q          <= rw_d;
      address_q     <= address_d;
      cache_reset_q <= cache_reset_d;
      dump_req_q    <= dump_req_d;
      reads_q       <= reads_d;
      writes_q      <= writes_d;
      bad_q         <= bad_d;
      idle_q        <= idle_d;
    end
  end

  assign acc_valid     = acc_valid_q;
  assign rw            = rw_q;
  assign address       = address_q;
  assign cache_reset   = cache_reset_q;
  assign dump_req      = dump_req_q;
  assign fifo_count    = count_q;
  assign issued_reads  = reads_q;
  assign issued_writes = writes_q;
  assign bad_ops       = bad_q;
  assign idle          = idle_q;

endmodule

// File: tb/tb_trace_access_driver.sv
// Testbench for trace_access_driver: a cycle table for the main flows plus
// hand-written sequences for FIFO-full/dump stall and reset during GAP.
module tb_trace_access_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // GAP=0 instance
  logic        reset, in_valid, in_ready, dump_ack;
  logic [3:0]  in_op;
  logic [15:0] in_addr, address;
  logic        acc_valid, rw, cache_reset, dump_req, idle;
  logic [3:0]  fifo_count;
  logic [31:0] issued_reads, issued_writes, bad_ops;

  // GAP=3 instance
  logic        reset_g, in_valid_g, in_ready_g, dump_ack_g;
  logic [3:0]  in_op_g;
  logic [15:0] in_addr_g, address_g;
  logic        acc_valid_g, rw_g, cache_reset_g, dump_req_g, idle_g;
  logic [3:0]  fifo_count_g;
  logic [31:0] issued_reads_g, issued_writes_g, bad_ops_g;

  trace_access_driver #(.ADDRESS_SIZE(16), .DEPTH(8), .GAP(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .acc_valid(acc_valid), .rw(rw),
    .address(address), .cache_reset(cache_reset), .dump_req(dump_req),
    .dump_ack(dump_ack), .fifo_count(fifo_count), .issued_reads(issued_reads),
    .issued_writes(issued_writes), .bad_ops(bad_ops), .idle(idle)
  );

  trace_access_driver #(.ADDRESS_SIZE(16), .DEPTH(8), .GAP(3)) dut_g (
    .clk(clk), .reset(reset_g), .in_valid(in_valid_g), .in_ready(in_ready_g),
    .in_op(in_op_g), .in_addr(in_addr_g), .acc_valid(acc_valid_g), .rw(rw_g),
    .address(address_g), .cache_reset(cache_reset_g), .dump_req(dump_req_g),
    .dump_ack(dump_ack_g), .fifo_count(fifo_count_g), .issued_reads(issued_reads_g),
    .issued_writes(issued_writes_g), .bad_ops(bad_ops_g), .idle(idle_g)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobes must never overlap on either instance.
  always @(negedge clk) begin
    if (!reset)
      chk("excl", 32'($countones({acc_valid, cache_reset, dump_req})) <= 1 ? 32'd1 : 32'd0, 32'd1);
    if (!reset_g)
      chk("excl_g", 32'($countones({acc_valid_g, cache_reset_g, dump_req_g})) <= 1 ? 32'd1 : 32'd0, 32'd1);
  end

  typedef struct {
    bit          rst;
    bit          iv;
    logic [3:0]  op;
    logic [15:0] addr;
    bit          acc;
    bit          rw;
    logic [15:0] ea;
    bit          cr;
    logic [3:0]  cnt;
    int          rd;
    int          wr;
    int          bd;
    bit          idl;
  } vec_t;

  function automatic vec_t v(bit rst, bit iv, logic [3:0] op, logic [15:0] addr,
                             bit acc, bit rwv, logic [15:0] ea, bit cr, logic [3:0] cnt,
                             int rd, int wr, int bd, bit idl);
    vec_t r;
    r.rst = rst; r.iv = iv; r.op = op; r.addr = addr;
    r.acc = acc; r.rw = rwv; r.ea = ea; r.cr = cr; r.cnt = cnt;
    r.rd = rd; r.wr = wr; r.bd = bd; r.idl = idl;
    return r;
  endfunction

  vec_t tbl[21];
  logic [15:0] got_q[$];
  int acc_seen;

  initial begin
    // Row = inputs applied before an edge, expected outputs after that edge.
    //          rst iv op    addr      acc rw ea        cr cnt rd wr bd idle
    tbl[0]  = v(0, 1, 4'd0, 16'h1234, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 4'd0, 16'h0000, 1, 0, 16'h1234, 0, 0, 1, 0, 0, 0);
    tbl[2]  = v(0, 0, 4'd0, 16'h0000, 0, 0, 16'h1234, 0, 0, 1, 0, 0, 1);
    tbl[3]  = v(0, 1, 4'd1, 16'h0100, 0, 0, 16'h1234, 0, 1, 1, 0, 0, 0);
    tbl[4]  = v(0, 1, 4'd1, 16'h0200, 1, 1, 16'h0100, 0, 1, 1, 1, 0, 0);
    tbl[5]  = v(0, 1, 4'd1, 16'h0300, 1, 1, 16'h0200, 0, 1, 1, 2, 0, 0);
    tbl[6]  = v(0, 1, 4'd1, 16'h0400, 1, 1, 16'h0300, 0, 1, 1, 3, 0, 0);
    tbl[7]  = v(0, 0, 4'd0, 16'h0000, 1, 1, 16'h0400, 0, 0, 1, 4, 0, 0);
    tbl[8]  = v(0, 0, 4'd0, 16'h0000, 0, 1, 16'h0400, 0, 0, 1, 4, 0, 1);
    tbl[9]  = v(0, 1, 4'd0, 16'h0010, 0, 1, 16'h0400, 0, 1, 1, 4, 0, 0);
    tbl[10] = v(0, 1, 4'd8, 16'h0000, 1, 0, 16'h0010, 0, 1, 2, 4, 0, 0);
    tbl[11] = v(0, 1, 4'd0, 16'h0020, 0, 0, 16'h0010, 1, 1, 2, 4, 0, 0);
    tbl[12] = v(0, 0, 4'd0, 16'h0000, 0, 0, 16'h0010, 1, 1, 2, 4, 0, 0);
    tbl[13] = v(0, 0, 4'd0, 16'h0000, 0, 0, 16'h0010, 0, 1, 2, 4, 0, 0);
    tbl[14] = v(0, 0, 4'd0, 16'h0000, 1, 0, 16'h0020, 0, 0, 3, 4, 0, 0);
    tbl[15] = v(0, 0, 4'd0, 16'h0000, 0, 0, 16'h0020, 0, 0, 3, 4, 0, 1);
    tbl[16] = v(1, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1);
    tbl[17] = v(0, 1, 4'd5, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0);
    tbl[18] = v(0, 1, 4'd2, 16'h00F0, 0, 0, 16'h0000, 0, 1, 0, 0, 1, 0);
    tbl[19] = v(0, 0, 4'd0, 16'h0000, 1, 0, 16'h00F0, 0, 0, 1, 0, 1, 0);
    tbl[20] = v(0, 0, 4'd0, 16'h0000, 0, 0, 16'h00F0, 0, 0, 1, 0, 1, 1);

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_addr = '0; dump_ack = 1'b0;
    reset_g = 1'b1; in_valid_g = 1'b0; in_op_g = '0; in_addr_g = '0; dump_ack_g = 1'b0;
    step(); step();
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_acc", 32'(acc_valid), 32'd0);

    for (int i = 0; i < 21; i++) begin
      reset    = tbl[i].rst;
      in_valid = tbl[i].iv;
      in_op    = tbl[i].op;
      in_addr  = tbl[i].addr;
      step();
      chk($sformatf("r%0d_acc", i),   32'(acc_valid),   32'(tbl[i].acc));
      chk($sformatf("r%0d_rw", i),    32'(rw),          32'(tbl[i].rw));
      chk($sformatf("r%0d_addr", i),  32'(address),     32'(tbl[i].ea));
      chk($sformatf("r%0d_crst", i),  32'(cache_reset), 32'(tbl[i].cr));
      chk($sformatf("r%0d_dreq", i),  32'(dump_req),    32'd0);
      chk($sformatf("r%0d_cnt", i),   32'(fifo_count),  32'(tbl[i].cnt));
      chk($sformatf("r%0d_reads", i), issued_reads,     32'(tbl[i].rd));
      chk($sformatf("r%0d_wrs", i),   issued_writes,    32'(tbl[i].wr));
      chk($sformatf("r%0d_bad", i),   bad_ops,          32'(tbl[i].bd));
      chk($sformatf("r%0d_idle", i),  32'(idle),        32'(tbl[i].idl));
    end
    in_valid = 1'b0;

    // Dump stall: fill the FIFO beyond DEPTH while dump_ack is low.
    reset = 1'b1; step(); reset = 1'b0;
    in_valid = 1'b1; in_op = 4'd9; in_addr = '0;
    step();
    acc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      in_op   = 4'd0;
      in_addr = 16'h1000 + 16'(i);
      step();
      if (acc_valid) acc_seen++;
    end
    in_valid = 1'b0;
    step(); step();
    chk("full_cnt",   32'(fifo_count), 32'd8);
    chk("full_ready", 32'(in_ready),   32'd0);
    chk("full_dreq",  32'(dump_req),   32'd1);
    chk("stall_acc",  32'(acc_seen),   32'd0);
    dump_ack = 1'b1;
    step();
    dump_ack = 1'b0;
    chk("ack_dreq", 32'(dump_req), 32'd0);
    for (int c = 0; c < 40; c++) begin
      step();
      if (acc_valid) got_q.push_back(address);
    end
    chk("drain_n", 32'(got_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < got_q.size()) chk($sformatf("drain_%0d", k), 32'(got_q[k]), 32'h1000 + 32'(k));
    end
    chk("drain_reads", issued_reads, 32'd8);
    chk("drain_idle",  32'(idle),    32'd1);

    // GAP=3 instance: single issue followed by three gap cycles.
    reset_g = 1'b0;
    in_valid_g = 1'b1; in_op_g = 4'd0; in_addr_g = 16'h0A0A;
    step();
    in_valid_g = 1'b0;
    chk("g_cnt1", 32'(fifo_count_g), 32'd1);
    step();
    chk("g_acc",  32'(acc_valid_g), 32'd1);
    chk("g_addr", 32'(address_g),   32'h0A0A);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("g_gap%0d_acc", c),  32'(acc_valid_g), 32'd0);
      chk($sformatf("g_gap%0d_idle", c), 32'(idle_g),       32'd0);
    end
    step();
    chk("g_idle_after", 32'(idle_g), 32'd1);

    // Reset while in GAP with two records queued.
    in_valid_g = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_addr_g = 16'h0B00 + 16'(i);
      step();
    end
    in_valid_g = 1'b0;
    chk("g_pre_cnt",   32'(fifo_count_g),  32'd2);
    chk("g_pre_acc",   32'(acc_valid_g),   32'd0);
    chk("g_pre_reads", issued_reads_g,     32'd2);
    chk("g_pre_idle",  32'(idle_g),        32'd0);
    reset_g = 1'b1;
    #1;
    chk("g_rst_cnt",   32'(fifo_count_g),  32'd0);
    chk("g_rst_addr",  32'(address_g),     32'd0);
    chk("g_rst_reads", issued_reads_g,     32'd0);
    chk("g_rst_idle",  32'(idle_g),        32'd1);
    chk("g_rst_acc",   32'(acc_valid_g),   32'd0);
    step(); step();
    reset_g = 1'b0;
    acc_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (acc_valid_g) acc_seen++;
    end
    chk("g_post_acc",  32'(acc_seen),       32'd0);
    chk("g_post_idle", 32'(idle_g),         32'd1);
    chk("g_post_rd",   issued_reads_g,      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
